div_stall_ctrl: RTL

- Multi-cycle radix-2 restoring divider for the EX stage of the five-stage MIPS pipeline.
- Produces the stall that holds the enable-gated pipeline registers while a DIV/DIVU is in progress.
- Delivers the quotient (LO) and remainder (HI) for the HI/LO write.
- Acts as the driving end of the pipeline-register enable interface: the registers consume the enable this block generates.

---
 rtl/div_stall_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/div_stall_ctrl.sv
// div_stall_ctrl: multi-cycle radix-2 restoring divider for the EX stage.
// Generates the pipeline stall while a DIV/DIVU iterates, then presents the
// sign-corrected quotient (lo) and remainder (hi) for the HI/LO write.
module div_stall_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ext_stall,
    input  logic             annul,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Iteration datapath: remainder accumulator, quotient/dividend shifter,
    // divisor magnitude and the two sign-correction flags.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic             accept;
    logic             last_step;

    // Two's-complement negation when n is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + ONE) : v;
    endfunction

    // Magnitude of an operand; raw value for unsigned divides. The most
    // negative value maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return cond_neg(v, s & v[WIDTH-1]);
    endfunction

    // One restoring step plus the stall/accept decode.
    always_comb begin
        rem_sh    = {rem, quo[WIDTH-1]};
        diff      = rem_sh - {1'b0, dvsr};
        fit       = ~diff[WIDTH];
        rem_nxt   = fit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt   = {quo[WIDTH-2:0], fit};
        q_fin     = cond_neg(quo_nxt, neg_q);
        r_fin     = cond_neg(rem_nxt, neg_r);
        last_step = (cnt == LAST);
        accept    = (state == IDLE) && start && !annul;
        // Low in DONE so the divide leaves EX on its result cycle; annul
        // releases the pipeline immediately.
        stall     = !annul && (((state == IDLE) && start) || (state == BUSY));
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lo           <= '0;
            hi           <= '0;
            result_valid <= 1'b0;
        end else if (annul) begin
            state        <= IDLE;
            cnt          <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        state        <= DONE;
                        lo           <= q_fin;
                        hi           <= r_fin;
                        result_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (!ext_stall) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: load operands on accept, iterate while BUSY.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem   <= '0;
            quo   <= mag(a, is_signed);
            dvsr  <= mag(b, is_signed);
            neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= is_signed & a[WIDTH-1];
        end else if (state == BUSY) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

endmodule
